alzette_dec_seq: RTL and testbench
==================================

Name: alzette_dec_seq

Overview:
- Iterative inverse Alzette ARX-box for the Sparkle RV64 datapath: undoes a full forward Alzette, all 4 steps, on one 64-bit {y,x} word under a 32-bit round constant c.
- Executes one inverse ARX step per cycle behind valid/ready request and response handshakes.
- Sits beside the single-step ISE unit as a standalone decryption coprocessor stage, feeding the permutation-inverse sequencer.

Parameters:
- ROUNDS, 4, number of inverse steps executed per request (legal 1..4). Steps always run in order 3,2,1,0; ROUNDS<4 stops after the first ROUNDS of them.

Ports:
- g_clk  input  1  clock, rising edge.
- g_resetn  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_data  input  64  {y[63:32], x[31:0]} ciphertext state.
- req_c  input  32  Alzette round constant c.
- flush  input  1  synchronous abort; discards any in-flight or held result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  64  {y', x'} recovered state.
- busy  output  1  high in RUN state.

Behaviour:
- Reset (g_resetn=0 at a g_clk edge):
  - state=IDLE, step counter=0.
  - x, y, c registers = 0.
  - req_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- Step k uses rotations (r_k, s_k): k=3 (24,16), k=2 (0,31), k=1 (17,17), k=0 (31,24). Rotations are rotate-right.
- One inverse step, all 32-bit and wrapping:
  - x1 = x ^ c
  - y1 = y ^ ror(x1, s_k)
  - x2 = x1 - ror(y1, r_k), mod 2^32
  - next state (x,y) = (x2, y1).
- FSM, states IDLE, RUN, DONE:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches x=req_data[31:0], y=req_data[63:32], c=req_c, sets counter=3, then goes to RUN.
  - RUN: req_ready=0, busy=1. Each cycle applies step[counter] and decrements the counter. After the ROUNDS-th step, go to DONE with the result registered.
  - DONE: rsp_valid=1 and rsp_data={y,x}, both held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency: with ROUNDS=4, a request accepted at edge N gives rsp_valid=1 after edge N+4.
- Throughput:
  - One request per ROUNDS+2 cycles when rsp_ready is held high.
  - No accept in the same cycle as the response handshake: req_ready only rises in IDLE.
- Backpressure: DONE holds indefinitely with rsp_ready=0; rsp_data must not change.
- Unmodified inputs: req_data and req_c are ignored outside an IDLE handshake. Changing them during RUN has no effect.
- flush=1 in any state: next state is IDLE, rsp_valid=0, counter=0. Data registers may keep stale values but must not be presented. flush has priority over a simultaneous request or response handshake, and that request is dropped.
- Reset in mid-RUN or DONE: identical to a power-on reset. No response is emitted for the aborted request.
- Arithmetic: subtraction wraps with no carry-out or flag. c is constant for all steps of a request.

Test Plan:
- Reset and idle: hold g_resetn=0 for 2 cycles, then release -> req_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- All zeros: req_data=0x00000000_00000000, req_c=0 -> rsp_data=0x00000000_00000000 exactly 4 cycles after accept.
- Known vector: req_data=0, req_c=0xFFFFFFFF -> rsp_data=0xFFFFFFFF_00000000. Intermediate {y,x} after steps 3,2,1,0: {FFFFFFFF,00000000}, {00000000,FFFFFFFF}, {00000000,00000000}, {FFFFFFFF,00000000}.
- Round trip: 1000 random (x,y,c) are forward-Alzetted by the software model and fed in -> every rsp_data equals the original {y,x}. rsp_ready is randomly stalled 0-5 cycles; rsp_data stays stable while stalled.
- Back-to-back with inputs toggled: req_valid held high with rsp_ready=1, and req_data/req_c changed during RUN -> each accepted request produces exactly one response, gap ROUNDS+2 cycles, using the accept-cycle values only.
- Abort: assert flush in the 2nd RUN cycle, and separately pull g_resetn low in DONE -> no rsp_valid pulse. Next request req_data=0, req_c=0xFFFFFFFF then completes with 0xFFFFFFFF_00000000.

Source files
------------

// File: rtl/alzette_dec_seq.sv
// Iterative inverse Alzette ARX-box: undoes a full forward Alzette on one {y,x} word.
// Latency: ROUNDS cycles from request accept to rsp_valid (one inverse step per cycle).
// Backpressure: DONE holds rsp_valid/rsp_data until rsp_ready; req_ready is high only in IDLE.
//
// Ports:
//   g_clk, g_resetn          clock (rising edge), synchronous active-low reset
//   req_valid/req_ready      request handshake; req_data = {y,x}, req_c = round constant
//   flush                    synchronous abort of any in-flight or held result
//   rsp_valid/rsp_ready      response handshake; rsp_data = recovered {y,x}
//   busy                     high while inverse steps are executing
module alzette_dec_seq #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_data,
  input  logic [31:0] req_c,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Steps always run 3,2,1,0; the last one executed is step (4 - ROUNDS).
  localparam logic [1:0] LAST_STEP = 2'(4 - ROUNDS);

  state_t      state;
  logic [1:0]  step_cnt;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [31:0] c_q;

  logic [4:0]  rot_r;
  logic [4:0]  rot_s;
  logic [31:0] x1;
  logic [31:0] y1;
  logic [31:0] x2;

  // Rotate right by 0..31: shift a doubled copy so n=0 needs no special case.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {v, v} >> n;
    return dbl[31:0];
  endfunction

  // Per-step rotation pair (r_k, s_k).
  always_comb begin
    rot_r = 5'd0;
    rot_s = 5'd0;
    case (step_cnt)
      2'd3: begin rot_r = 5'd24; rot_s = 5'd16; end
      2'd2: begin rot_r = 5'd0;  rot_s = 5'd31; end
      2'd1: begin rot_r = 5'd17; rot_s = 5'd17; end
      2'd0: begin rot_r = 5'd31; rot_s = 5'd24; end
      default: begin rot_r = 5'd0; rot_s = 5'd0; end
    endcase
  end

  // One inverse step: exact reverse of forward x+=ror(y,r); y^=ror(x,s); x^=c.
  always_comb begin
    x1 = x_q ^ c_q;
    y1 = y_q ^ ror32(x1, rot_s);
    x2 = x1 - ror32(y1, rot_r);
  end

  // Data registers double as the result register; only exposed as valid in DONE.
  assign rsp_data = {y_q, x_q};

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state     <= S_IDLE;
      step_cnt  <= 2'd0;
      x_q       <= 32'd0;
      y_q       <= 32'd0;
      c_q       <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      // Abort wins over any same-cycle handshake; stale data stays but is never valid.
      state     <= S_IDLE;
      step_cnt  <= 2'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            x_q       <= req_data[31:0];
            y_q       <= req_data[63:32];
            c_q       <= req_c;
            step_cnt  <= 2'd3;
            state     <= S_RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          x_q <= x2;
          y_q <= y1;
          if (step_cnt == LAST_STEP) begin
            step_cnt  <= 2'd0;
            state     <= S_DONE;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            step_cnt <= step_cnt - 2'd1;
          end
        end
        S_DONE: begin
          // req_ready only rises here, so no accept can share the response cycle.
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          step_cnt  <= 2'd0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alzette_dec_seq.sv
// Bench for alzette_dec_seq: directed steps plus a random forward/inverse round trip.
// Expected results are queued at request time and popped when the response handshakes.
// A negedge monitor owns rsp_ready (always-ready, random stall or forced low).
module tb_alzette_dec_seq;

  localparam int ROUNDS = 4;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_data;
  logic [31:0] req_c;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] exp_q[$];
  int          rsp_cyc[$];
  bit          stall_mode = 1'b0;
  bit          hold_low   = 1'b0;

  alzette_dec_seq #(.ROUNDS(ROUNDS)) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_c     (req_c),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  // Forward Alzette, steps 0..3, used to build ciphertexts with a known answer.
  function automatic logic [63:0] alz_fwd(input logic [31:0] x_in, input logic [31:0] y_in,
                                          input logic [31:0] c);
    logic [31:0] x;
    logic [31:0] y;
    int r;
    int s;
    x = x_in;
    y = y_in;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin r = 31; s = 24; end
        1: begin r = 17; s = 17; end
        2: begin r = 0;  s = 31; end
        default: begin r = 24; s = 16; end
      endcase
      x = x + rr(y, r);
      y = y ^ rr(x, s);
      x = x ^ c;
    end
    return {y, x};
  endfunction

  // Response monitor: decides rsp_ready for the coming edge and scores handshakes.
  bit          in_rsp = 1'b0;
  logic [63:0] held;
  int          stall_left = 0;
  always @(negedge g_clk) begin
    if (!rsp_valid) begin
      in_rsp    = 1'b0;
      rsp_ready = !hold_low;
    end else begin
      if (!in_rsp) begin
        in_rsp     = 1'b1;
        held       = rsp_data;
        stall_left = stall_mode ? $urandom_range(0, 5) : 0;
      end else begin
        check("rsp_stable", rsp_data, held);
      end
      if (hold_low) begin
        rsp_ready = 1'b0;
      end else if (stall_left > 0) begin
        rsp_ready = 1'b0;
        stall_left--;
      end else begin
        rsp_ready = 1'b1;
      end
      if (rsp_ready) begin
        check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("rsp_data", rsp_data, exp_q.pop_front());
        rsp_cyc.push_back(cyc);
        in_rsp = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic [63:0] d, input logic [31:0] c, input logic [63:0] e);
    int g = 0;
    while (!req_ready && g < 100) begin
      @(posedge g_clk); #1;
      g++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_data  = d;
    req_c     = c;
    exp_q.push_back(e);
    @(posedge g_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((exp_q.size() != 0 || rsp_valid) && g < 200) begin
      @(posedge g_clk); #1;
      g++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic quiet_window(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge g_clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] ox, oy, oc;
    logic [63:0] ct;

    g_resetn  = 1'b0;
    req_valid = 1'b0;
    req_data  = 64'd0;
    req_c     = 32'd0;
    flush     = 1'b0;

    // Reset and idle
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  rsp_data,       64'd0);
    check("rst_busy",      64'(busy),      64'd0);

    // All zeros, with latency
    send(64'd0, 32'd0, 64'd0);
    check("run_busy", 64'(busy), 64'd1);
    check("run_req_ready", 64'(req_ready), 64'd0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge g_clk); #1;
      if (rsp_valid) begin n = i; break; end
    end
    check("latency_zero", 64'(n), 64'(ROUNDS));
    drain("drain_zero");

    // Known vector with intermediate states
    send(64'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    @(posedge g_clk); #1;
    check("kv_step3", rsp_data, 64'hFFFF_FFFF_0000_0000);
    check("kv_step3_vld", 64'(rsp_valid), 64'd0);
    @(posedge g_clk); #1;
    check("kv_step2", rsp_data, 64'h0000_0000_FFFF_FFFF);
    @(posedge g_clk); #1;
    check("kv_step1", rsp_data, 64'h0000_0000_0000_0000);
    @(posedge g_clk); #1;
    check("kv_step0", rsp_data, 64'hFFFF_FFFF_0000_0000);
    check("kv_done_vld", 64'(rsp_valid), 64'd1);
    check("kv_done_busy", 64'(busy), 64'd0);
    drain("drain_kv");

    // Backpressure: DONE held with rsp_ready low
    hold_low = 1'b1;
    ox = 32'h1234_5678; oy = 32'h9ABC_DEF0; oc = 32'h0F0F_1E1E;
    send(alz_fwd(ox, oy, oc), 32'hDEAD_BEEF ^ 32'hDEAD_BEEF ^ oc, {oy, ox});
    repeat (ROUNDS + 1) @(posedge g_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      @(posedge g_clk); #1;
      check("bp_hold_vld", 64'(rsp_valid), 64'd1);
    end
    check("bp_hold_rdy", 64'(req_ready), 64'd0);
    hold_low = 1'b0;
    drain("drain_bp");

    // Flush has priority over a same-cycle request in IDLE
    req_valid = 1'b1;
    req_data  = 64'h5555_AAAA_3333_CCCC;
    req_c     = 32'h1;
    flush     = 1'b1;
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);
    check("flush_idle_rdy",  64'(req_ready), 64'd1);
    quiet_window("flush_idle_quiet", 8);

    // Round trip with random response stalls
    stall_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ox = $urandom; oy = $urandom; oc = $urandom;
      ct = alz_fwd(ox, oy, oc);
      send(ct, oc, {oy, ox});
    end
    drain("drain_random");
    stall_mode = 1'b0;

    // Back-to-back, inputs toggled during RUN
    rsp_cyc.delete();
    req_valid = 1'b1;
    n = 0;
    for (int g = 0; g < 200 && n < 6; g++) begin
      if (req_ready) begin
        ox = $urandom; oy = $urandom; oc = $urandom;
        req_data = alz_fwd(ox, oy, oc);
        req_c    = oc;
        exp_q.push_back({oy, ox});
        n++;
      end else begin
        req_data = {$urandom, $urandom};
        req_c    = $urandom;
      end
      @(posedge g_clk); #1;
    end
    req_valid = 1'b0;
    drain("drain_b2b");
    check("b2b_count", 64'(rsp_cyc.size()), 64'd6);
    for (int i = 1; i < rsp_cyc.size(); i++)
      check("b2b_gap", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'(ROUNDS + 2));

    // Abort: flush in the second RUN cycle
    send(64'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    @(posedge g_clk); #1;
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(posedge g_clk); #1;
    flush = 1'b0;
    check("flush_run_vld",  64'(rsp_valid), 64'd0);
    check("flush_run_busy", 64'(busy), 64'd0);
    check("flush_run_rdy",  64'(req_ready), 64'd1);
    quiet_window("flush_run_quiet", 10);

    // Abort: reset while in DONE
    hold_low = 1'b1;
    send(64'h0123_4567_89AB_CDEF, 32'h7, 64'd0);
    n = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge g_clk); #1;
    end
    check("rst_done_reach", 64'(rsp_valid), 64'd1);
    g_resetn = 1'b0;
    void'(exp_q.pop_back());
    @(posedge g_clk); #1;
    check("rst_done_vld",  64'(rsp_valid), 64'd0);
    check("rst_done_data", rsp_data, 64'd0);
    check("rst_done_rdy",  64'(req_ready), 64'd1);
    check("rst_done_busy", 64'(busy), 64'd0);
    g_resetn = 1'b1;
    hold_low = 1'b0;
    quiet_window("rst_done_quiet", 10);

    // Recovery request after aborts
    send(64'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
